silife_row_write_queue: RTL and testbench

Buffers row writes from the pattern loader (demo loader or any other row-oriented source) and replays them into the cell grid's row-write port only while the generation engine is not busy. Sits directly downstream of the demo loader: its `in_ready` drives the loader's `en`, so the loader stalls when the queue is full. Same-row writes still queued are coalesced so the grid only sees the latest contents.

---
 rtl/silife_row_write_queue.sv | 117 +++++++++++
 tb/tb_silife_row_write_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/silife_row_write_queue.sv
// Row-write queue between the pattern loader and the cell grid.
// Buffers row writes, coalesces repeat writes to the newest queued row,
// and replays entries as one-cycle grid strobes while the engine is idle.
module silife_row_write_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ROW_BITS = 5,
   parameter int unsigned WIDTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ROW_BITS-1:0]       in_row,
   input  logic [WIDTH-1:0]          in_cells,
   input  logic                      in_wr_en,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic                      grid_busy,
   output logic [ROW_BITS-1:0]       grid_row,
   output logic [WIDTH-1:0]          grid_cells,
   output logic                      grid_wr_en,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      idle
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ROW_BITS-1:0] row_mem_q   [DEPTH];
   logic [WIDTH-1:0]    cells_mem_q [DEPTH];

   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ROW_BITS-1:0] grid_row_q, grid_row_d;
   logic [WIDTH-1:0]    grid_cells_q, grid_cells_d;
   logic                grid_wr_en_q, grid_wr_en_d;

   logic                accept;
   logic                pop;
   logic                coalesce;
   logic                alloc;
   logic [PTR_W-1:0]    newest_ptr;

   // Handshake and status decoded from state only, never from in_wr_en
   assign in_ready   = (count_q != CNT_W'(DEPTH));
   assign idle       = (count_q == '0) && !grid_wr_en_q;
   assign grid_row   = grid_row_q;
   assign grid_cells = grid_cells_q;
   assign grid_wr_en = grid_wr_en_q;
   assign count      = count_q;

   // Accept/pop decode; the newest entry may be merged only if it is not leaving this edge
   always_comb begin
      accept     = in_wr_en && in_ready;
      pop        = (count_q != '0) && !grid_busy && !flush;
      newest_ptr = wr_ptr_q - PTR_W'(1);
      coalesce   = accept && (count_q != '0)
                   && (row_mem_q[newest_ptr] == in_row)
                   && ((count_q >= CNT_W'(2)) || !pop);
      alloc      = accept && !coalesce;
   end

   // Next-state for pointers, occupancy and the grid-side output register
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      grid_row_d   = grid_row_q;
      grid_cells_d = grid_cells_q;
      grid_wr_en_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (alloc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            grid_row_d   = row_mem_q[rd_ptr_q];
            grid_cells_d = cells_mem_q[rd_ptr_q];
            grid_wr_en_d = 1'b1;
         end
         count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         grid_row_q   <= '0;
         grid_cells_q <= '0;
         grid_wr_en_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         grid_row_q   <= grid_row_d;
         grid_cells_q <= grid_cells_d;
         grid_wr_en_q <= grid_wr_en_d;
      end
   end

   // Entry storage: merge into the newest entry or write the tail; contents need no reset
   always_ff @(posedge clk) begin
      if (accept && !flush) begin
         if (coalesce) begin
            cells_mem_q[newest_ptr] <= in_cells;
         end else begin
            row_mem_q[wr_ptr_q]   <= in_row;
            cells_mem_q[wr_ptr_q] <= in_cells;
         end
      end
   end

endmodule

// File: tb/tb_silife_row_write_queue.sv
// Directed self-checking bench for silife_row_write_queue.
module tb_silife_row_write_queue;

   logic       clk;
   logic       rst_n;
   logic [4:0] in_row;
   logic [7:0] in_cells;
   logic       in_wr_en;
   logic       in_ready;
   logic       flush;
   logic       grid_busy;
   logic [4:0] grid_row;
   logic [7:0] grid_cells;
   logic       grid_wr_en;
   logic [2:0] count;
   logic       idle;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] log_row   [$];
   logic [7:0] log_cells [$];

   silife_row_write_queue #(.DEPTH(4), .ROW_BITS(5), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_row(in_row), .in_cells(in_cells), .in_wr_en(in_wr_en), .in_ready(in_ready),
      .flush(flush), .grid_busy(grid_busy),
      .grid_row(grid_row), .grid_cells(grid_cells), .grid_wr_en(grid_wr_en),
      .count(count), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every grid strobe mid-cycle
   always @(negedge clk) begin
      if (rst_n && grid_wr_en) begin
         log_row.push_back(grid_row);
         log_cells.push_back(grid_cells);
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic put(input logic [4:0] r, input logic [7:0] c);
      in_row   = r;
      in_cells = c;
      in_wr_en = 1'b1;
      tick();
      in_wr_en = 1'b0;
   endtask

   task automatic clear_log();
      log_row.delete();
      log_cells.delete();
   endtask

   function automatic logic [7:0] pat(input int r);
      return 8'(r * 37 + 5);
   endfunction

   initial begin
      int r;
      int cyc;
      logic acc;

      rst_n = 1'b0; in_row = '0; in_cells = '0; in_wr_en = 1'b0;
      flush = 1'b0; grid_busy = 1'b0;
      #12;
      chk_eq("rst_ready", 32'(in_ready), 32'd1);
      chk_eq("rst_idle", 32'(idle), 32'd1);
      chk_eq("rst_count", 32'(count), 32'd0);
      chk_eq("rst_wr_en", 32'(grid_wr_en), 32'd0);
      rst_n = 1'b1;
      tick();

      // Three back-to-back writes, engine idle: one-cycle latency, full throughput
      clear_log();
      in_wr_en = 1'b1; in_row = 5'd0; in_cells = 8'h10;
      tick();
      chk_eq("t1_wr_en0", 32'(grid_wr_en), 32'd0);
      chk_eq("t1_count0", 32'(count), 32'd1);
      in_row = 5'd1; in_cells = 8'h11;
      tick();
      chk_eq("t1_wr_en1", 32'(grid_wr_en), 32'd1);
      chk_eq("t1_row1", 32'(grid_row), 32'd0);
      in_row = 5'd2; in_cells = 8'h12;
      tick();
      chk_eq("t1_wr_en2", 32'(grid_wr_en), 32'd1);
      chk_eq("t1_row2", 32'(grid_row), 32'd1);
      in_wr_en = 1'b0;
      tick();
      chk_eq("t1_wr_en3", 32'(grid_wr_en), 32'd1);
      chk_eq("t1_row3", 32'(grid_row), 32'd2);
      chk_eq("t1_cells3", 32'(grid_cells), 32'h12);
      tick();
      chk_eq("t1_wr_en4", 32'(grid_wr_en), 32'd0);
      chk_eq("t1_idle", 32'(idle), 32'd1);
      chk_eq("t1_nwrites", 32'(log_row.size()), 32'd3);

      // Demo-loader stream of 32 rows against a busy, then free, grid
      clear_log();
      grid_busy = 1'b1;
      in_wr_en  = 1'b1;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         in_row = 5'(r); in_cells = pat(r);
         acc = in_ready;
         tick();
         if (acc) r++;
      end
      chk_eq("t2_accepted", 32'(r), 32'd4);
      chk_eq("t2_count_full", 32'(count), 32'd4);
      chk_eq("t2_not_ready", 32'(in_ready), 32'd0);
      chk_eq("t2_no_write_busy", 32'(log_row.size()), 32'd0);
      grid_busy = 1'b0;
      cyc = 0;
      while (r < 32 && cyc < 400) begin
         in_row = 5'(r); in_cells = pat(r);
         acc = in_ready;
         tick();
         if (acc) r++;
         cyc++;
      end
      in_wr_en = 1'b0;
      chk_eq("t2_all_accepted", 32'(r), 32'd32);
      cyc = 0;
      while (!idle && cyc < 50) begin
         tick();
         cyc++;
      end
      chk_eq("t2_drained", 32'(idle), 32'd1);
      chk_eq("t2_nwrites", 32'(log_row.size()), 32'd32);
      for (int i = 0; i < 32 && i < log_row.size(); i++) begin
         chk_eq($sformatf("t2_row%0d", i), 32'(log_row[i]), 32'(i));
         chk_eq($sformatf("t2_cells%0d", i), 32'(log_cells[i]), 32'(pat(i)));
      end

      // Same row written twice while busy: merged into one entry
      clear_log();
      grid_busy = 1'b1;
      put(5'd7, 8'h0F);
      put(5'd7, 8'hF0);
      chk_eq("t3_count", 32'(count), 32'd1);
      grid_busy = 1'b0;
      ticks(4);
      chk_eq("t3_nwrites", 32'(log_row.size()), 32'd1);
      if (log_row.size() >= 1) begin
         chk_eq("t3_row", 32'(log_row[0]), 32'd7);
         chk_eq("t3_cells", 32'(log_cells[0]), 32'hF0);
      end

      // Same row arrives on the edge its only entry is popped: no merge
      clear_log();
      grid_busy = 1'b1;
      put(5'd5, 8'hAA);
      chk_eq("t4_count", 32'(count), 32'd1);
      grid_busy = 1'b0;
      put(5'd5, 8'h55);
      chk_eq("t4_count_after", 32'(count), 32'd1);
      ticks(4);
      chk_eq("t4_nwrites", 32'(log_row.size()), 32'd2);
      if (log_row.size() >= 2) begin
         chk_eq("t4_cells0", 32'(log_cells[0]), 32'hAA);
         chk_eq("t4_cells1", 32'(log_cells[1]), 32'h55);
      end

      // Flush at count 3 with a strobe in flight and a write presented
      clear_log();
      grid_busy = 1'b1;
      put(5'd1, 8'h11);
      put(5'd2, 8'h22);
      put(5'd3, 8'h33);
      put(5'd4, 8'h44);
      grid_busy = 1'b0;
      tick();
      chk_eq("t5_count3", 32'(count), 32'd3);
      chk_eq("t5_strobe", 32'(grid_wr_en), 32'd1);
      flush = 1'b1; in_wr_en = 1'b1; in_row = 5'd9; in_cells = 8'h99;
      tick();
      flush = 1'b0; in_wr_en = 1'b0;
      chk_eq("t5_count0", 32'(count), 32'd0);
      chk_eq("t5_wr_en0", 32'(grid_wr_en), 32'd0);
      chk_eq("t5_row_hold", 32'(grid_row), 32'd1);
      ticks(5);
      chk_eq("t5_nwrites", 32'(log_row.size()), 32'd1);
      chk_eq("t5_idle", 32'(idle), 32'd1);

      // Asynchronous reset mid-burst with count 2 and a strobe high
      clear_log();
      grid_busy = 1'b1;
      put(5'd1, 8'h11);
      put(5'd2, 8'h22);
      put(5'd3, 8'h33);
      grid_busy = 1'b0;
      tick();
      chk_eq("t6_count2", 32'(count), 32'd2);
      chk_eq("t6_strobe", 32'(grid_wr_en), 32'd1);
      grid_busy = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk_eq("t6_rst_wr_en", 32'(grid_wr_en), 32'd0);
      chk_eq("t6_rst_count", 32'(count), 32'd0);
      chk_eq("t6_rst_row", 32'(grid_row), 32'd0);
      chk_eq("t6_rst_cells", 32'(grid_cells), 32'd0);
      chk_eq("t6_rst_ready", 32'(in_ready), 32'd1);
      chk_eq("t6_rst_idle", 32'(idle), 32'd1);
      #10 rst_n = 1'b1;
      grid_busy = 1'b0;
      ticks(3);
      chk_eq("t6_post_ready", 32'(in_ready), 32'd1);
      chk_eq("t6_post_idle", 32'(idle), 32'd1);
      chk_eq("t6_post_nwrites", 32'(log_row.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
